ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch stage between the program counter and the decoder. Fetches the word at the PC's `current_pc` from instruction memory over a req/ack handshake and holds it in an instruction register with its PC. Presents the word to the decoder over a valid/ready handshake, then pulses `pc_advance` to drive the PC's `op` input. Detects misaligned PCs, bus errors and memory timeouts, and supports a flush for redirects.

## Interface
- `TIMEOUT`, 255: wait cycles without ack before a timeout fault; legal range 1..65535.
- `sys_clk`  in  1  clock; all state changes on rising edge.
- `sys_rst`  in  1  reset, asynchronous, active-high.
- `current_pc`  in  32  address of the next instruction, from the PC.
- `pc_advance`  out  1  one-cycle pulse; PC steps to its next value.
- `imem_req`  out  1  memory request; level, held until ack.
- `imem_addr`  out  32  fetch address; stable while `imem_req`=1.
- `imem_ack`  in  1  memory completion; sampled only while `imem_req`=1.
- `imem_rdata`  in  32  read data; valid with `imem_ack`.
- `imem_err`  in  1  bus error; qualified by `imem_ack`.
- `inst_valid`  out  1  `inst` / `inst_pc` hold a valid instruction.
- `inst_ready`  in  1  decoder accepts; transfer when valid & ready.
- `inst`  out  32  instruction word.
- `inst_pc`  out  32  address the instruction was fetched from.
- `flush`  in  1  discard the held or in-flight instruction.
- `fault`  out  1  sticky fault flag.
- `fault_cause`  out  2  cause code: 01 misaligned, 10 bus error, 11 timeout, 00 none.
- `fault_pc`  out  32  PC of the faulting fetch.
- `fault_clr`  in  1  clears the fault and resumes fetching.

## Operation
- FSM states: IDLE, WAIT, HOLD, ADV, FAULT. All outputs are registered.
- IDLE, `current_pc[1:0]`≠0: go to FAULT. Set cause 01 and `fault_pc`=`current_pc`. No request is issued.
- IDLE, aligned PC: latch `imem_addr`=`current_pc`, set `imem_req`=1, clear `wait_cnt` (16-bit), go to WAIT.
- WAIT, ack & !err: capture `inst`=`imem_rdata` and `inst_pc`=`imem_addr`. Drop `imem_req`. Go to HOLD with `inst_valid`=1.
- WAIT, ack & err: drop `imem_req`. Go to FAULT with cause 10 and `fault_pc`=`imem_addr`.
- WAIT, no ack, `wait_cnt`==TIMEOUT: drop `imem_req`. Go to FAULT with cause 11.
- WAIT, no ack otherwise: `wait_cnt`++. Counter saturates; it never wraps.
- HOLD: `inst`, `inst_pc` and `inst_valid` stay stable until the transfer. On valid & ready, clear `inst_valid` and go to ADV.
- ADV: `pc_advance`=1 for exactly this cycle, then go to IDLE.
- FAULT: `fault`=1 and held. `fault_clr` clears `fault`, `fault_cause` and `fault_pc` to 0, then goes to IDLE.
- Flush in WAIT: the bus access is never aborted. Set a discard flag; on ack, drop the data and go to IDLE. No `inst_valid` and no `pc_advance`. If `imem_err` arrives during discard, it is ignored. A timeout during discard still faults.
- Flush in HOLD: clear `inst_valid` and go to IDLE. Flush and handshake in the same cycle: flush wins, no transfer, no `pc_advance`.
- Flush in IDLE, ADV or FAULT: no effect. A `pc_advance` already in flight is still issued.
- `fault_clr` outside FAULT: ignored.

## Timing
- Reset: state IDLE; all outputs 0; discard flag 0; `wait_cnt` 0.
- First edge after reset release: `imem_req` rises.
- Zero-wait memory with `inst_ready` held high:
  - IDLE c0, WAIT c1 (ack c1), HOLD c2 (`inst_valid`), ADV c3 (`pc_advance`), IDLE c4.
  - Throughput: one instruction per 4 cycles.
- Each ack-wait cycle adds one cycle. Ack is accepted in any of the first TIMEOUT+1 WAIT cycles; the fault registers on the following edge.
- `current_pc` is sampled only in IDLE. The PC must have applied `pc_advance` before the ADV→IDLE edge completes.
- Reset mid-operation: immediate return to the reset values. Any outstanding memory ack after reset is ignored (`imem_req`=0).

## Test plan
- Zero-wait fetch, `current_pc`=0x0, rdata 0x00500093, ready=1 -> `inst`=0x00500093, `inst_pc`=0; `inst_valid` high in c2; `pc_advance` high in c3 only.
- Ack after 3 wait cycles, ready low for 5 cycles -> `inst` stable throughout; exactly one `pc_advance`, in the cycle after ready rises.
- `current_pc`=0x6 -> `imem_req` never rises; `fault`=1, cause 01, `fault_pc`=0x6. `fault_clr` with PC=0x8 -> fetch from 0x8.
- TIMEOUT=4, no ack -> `imem_req` high for 5 cycles, then `fault`=1 with cause 11. Separate case: ack with `imem_err` -> cause 10.
- Flush in WAIT, ack 2 cycles later -> data discarded, no `inst_valid`, no `pc_advance`, new request issued. Flush with valid & ready in the same cycle -> no `pc_advance`.
- `sys_rst` pulse asynchronously while in WAIT -> all outputs 0 immediately. A late ack is ignored; a fresh request issues after release.

Source files
------------

// File: rtl/ifetch.sv
// Instruction fetch stage: pulls one word per PC value from instruction memory,
// hands it to the decoder, then pulses pc_advance. Faults are sticky until fault_clr.
module ifetch #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [31:0] current_pc,
    output logic        pc_advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        flush,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_pc,
    input  logic        fault_clr
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_ADV   = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic [1:0]  CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0]  CAUSE_BUS      = 2'b10;
    localparam logic [1:0]  CAUSE_TIMEOUT  = 2'b11;
    localparam logic [15:0] TIMEOUT_CNT    = 16'(TIMEOUT);

    state_t      state;
    logic [15:0] wait_cnt;
    logic        discard;
    logic        drop;

    // A flush arriving in the same cycle as the ack discards that response too.
    assign drop = discard | flush;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            discard     <= 1'b0;
            pc_advance  <= 1'b0;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            inst_valid  <= 1'b0;
            inst        <= '0;
            inst_pc     <= '0;
            fault       <= 1'b0;
            fault_cause <= '0;
            fault_pc    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (current_pc[1:0] != 2'b00) begin
                        fault       <= 1'b1;
                        fault_cause <= CAUSE_MISALIGN;
                        fault_pc    <= current_pc;
                        state       <= S_FAULT;
                    end else begin
                        imem_addr <= current_pc;
                        imem_req  <= 1'b1;
                        wait_cnt  <= '0;
                        discard   <= 1'b0;
                        state     <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        discard  <= 1'b0;
                        if (drop) begin
                            // Redirected while in flight: bus errors are moot here.
                            state <= S_IDLE;
                        end else if (imem_err) begin
                            fault       <= 1'b1;
                            fault_cause <= CAUSE_BUS;
                            fault_pc    <= imem_addr;
                            state       <= S_FAULT;
                        end else begin
                            inst       <= imem_rdata;
                            inst_pc    <= imem_addr;
                            inst_valid <= 1'b1;
                            state      <= S_HOLD;
                        end
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        imem_req    <= 1'b0;
                        discard     <= 1'b0;
                        fault       <= 1'b1;
                        fault_cause <= CAUSE_TIMEOUT;
                        fault_pc    <= imem_addr;
                        state       <= S_FAULT;
                    end else begin
                        if (wait_cnt != 16'hFFFF)
                            wait_cnt <= wait_cnt + 16'd1;
                        discard <= drop;
                    end
                end

                S_HOLD: begin
                    if (flush) begin
                        inst_valid <= 1'b0;
                        state      <= S_IDLE;
                    end else if (inst_ready) begin
                        inst_valid <= 1'b0;
                        pc_advance <= 1'b1;
                        state      <= S_ADV;
                    end
                end

                S_ADV: begin
                    pc_advance <= 1'b0;
                    state      <= S_IDLE;
                end

                S_FAULT: begin
                    if (fault_clr) begin
                        fault       <= 1'b0;
                        fault_cause <= '0;
                        fault_pc    <= '0;
                        state       <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed scenarios followed by randomized fetch traffic,
// checked against a transaction-level model of PC, memory and fault behaviour.
module tb_ifetch;

    localparam int TO = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [31:0] current_pc;
    logic        pc_advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        flush;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fault_pc;
    logic        fault_clr;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] pc;

    ifetch #(.TIMEOUT(TO)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .current_pc(current_pc),
        .pc_advance(pc_advance), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .imem_err(imem_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .flush(flush), .fault(fault),
        .fault_cause(fault_cause), .fault_pc(fault_pc), .fault_clr(fault_clr)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Called in the first WAIT cycle; ends in the IDLE cycle after ADV.
    task automatic finish_fetch(input int w, input int r, input logic [31:0] d);
        for (int i = 0; i < w; i++) begin
            imem_ack = 1'b0;
            tick();
            check1("req_held", imem_req, 1'b1);
            check32("addr_stable", imem_addr, pc);
        end
        imem_ack   = 1'b1;
        imem_err   = 1'b0;
        imem_rdata = d;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        check1("hold_valid", inst_valid, 1'b1);
        check32("hold_inst", inst, d);
        check32("hold_inst_pc", inst_pc, pc);
        check1("hold_req_low", imem_req, 1'b0);
        for (int i = 0; i < r; i++) begin
            inst_ready = 1'b0;
            tick();
            check1("stall_valid", inst_valid, 1'b1);
            check32("stall_inst", inst, d);
            check1("stall_no_adv", pc_advance, 1'b0);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check1("adv_pulse", pc_advance, 1'b1);
        check1("adv_valid_low", inst_valid, 1'b0);
        if ($urandom_range(0, 7) == 0) pc = $urandom & 32'hFFFF_FFFC;
        else pc = pc + 32'd4;
        current_pc = pc;
        tick();
        check1("adv_one_cycle", pc_advance, 1'b0);
    endtask

    // Called in an IDLE cycle with an aligned PC.
    task automatic do_fetch(input int w, input int r, input logic [31:0] d);
        tick();
        check1("req_rise", imem_req, 1'b1);
        check32("req_addr", imem_addr, pc);
        check1("wait_valid_low", inst_valid, 1'b0);
        finish_fetch(w, r, d);
    endtask

    task automatic clear_fault();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check1("clr_fault", fault, 1'b0);
        check32("clr_cause", 32'(fault_cause), 32'd0);
        check32("clr_fault_pc", fault_pc, 32'd0);
    endtask

    initial begin
        int n;
        int k;
        sys_rst    = 1'b1;
        current_pc = 32'd0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        imem_err   = 1'b0;
        inst_ready = 1'b0;
        flush      = 1'b0;
        fault_clr  = 1'b0;
        pc         = 32'd0;

        #12;
        check1("rst_req", imem_req, 1'b0);
        check1("rst_valid", inst_valid, 1'b0);
        check1("rst_adv", pc_advance, 1'b0);
        check1("rst_fault", fault, 1'b0);
        check32("rst_cause", 32'(fault_cause), 32'd0);
        check32("rst_addr", imem_addr, 32'd0);
        check32("rst_inst", inst, 32'd0);
        tick();
        sys_rst = 1'b0;

        // Zero-wait fetch, then waited fetch with a stalled decoder, then ack on the last legal cycle.
        do_fetch(0, 0, 32'h0050_0093);
        do_fetch(3, 5, $urandom);
        do_fetch(TO, 1, $urandom);

        // Misaligned PC: no request, sticky fault, flush has no effect.
        pc = 32'h6;
        current_pc = pc;
        tick();
        check1("mis_fault", fault, 1'b1);
        check32("mis_cause", 32'(fault_cause), 32'd1);
        check32("mis_fault_pc", fault_pc, 32'h6);
        for (int i = 0; i < 3; i++) begin
            flush = (i == 1);
            tick();
            check1("mis_no_req", imem_req, 1'b0);
            check1("mis_sticky", fault, 1'b1);
        end
        flush = 1'b0;
        pc = 32'h8;
        current_pc = pc;
        clear_fault();
        do_fetch(0, 0, $urandom);

        // Timeout: request held for TIMEOUT+1 cycles, then fault.
        n = 0;
        tick();
        while (imem_req === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        check32("to_req_cycles", n, TO + 1);
        check1("to_fault", fault, 1'b1);
        check32("to_cause", 32'(fault_cause), 32'd3);
        check32("to_fault_pc", fault_pc, pc);
        clear_fault();

        // Bus error.
        tick();
        check1("be_req", imem_req, 1'b1);
        imem_ack = 1'b1;
        imem_err = 1'b1;
        tick();
        imem_ack = 1'b0;
        imem_err = 1'b0;
        check1("be_fault", fault, 1'b1);
        check32("be_cause", 32'(fault_cause), 32'd2);
        check32("be_fault_pc", fault_pc, pc);
        check1("be_no_valid", inst_valid, 1'b0);
        clear_fault();

        // Flush in WAIT, erroring ack two cycles later: dropped silently, refetch same PC.
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        imem_ack = 1'b1;
        imem_err = 1'b1;
        tick();
        imem_ack = 1'b0;
        imem_err = 1'b0;
        check1("fw_no_valid", inst_valid, 1'b0);
        check1("fw_no_fault", fault, 1'b0);
        check1("fw_req_low", imem_req, 1'b0);
        check1("fw_no_adv", pc_advance, 1'b0);
        do_fetch(1, 0, $urandom);

        // Flush in WAIT followed by a timeout still faults.
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n = 0;
        while (imem_req === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        check32("ft_req_cycles", n, TO);
        check1("ft_fault", fault, 1'b1);
        check32("ft_cause", 32'(fault_cause), 32'd3);
        clear_fault();

        // Flush and handshake together in HOLD: flush wins.
        tick();
        imem_ack = 1'b1;
        imem_rdata = $urandom;
        tick();
        imem_ack = 1'b0;
        check1("fh_valid", inst_valid, 1'b1);
        flush = 1'b1;
        inst_ready = 1'b1;
        tick();
        flush = 1'b0;
        inst_ready = 1'b0;
        check1("fh_valid_low", inst_valid, 1'b0);
        check1("fh_no_adv", pc_advance, 1'b0);
        tick();
        check1("fh_no_adv2", pc_advance, 1'b0);
        check1("fh_refetch", imem_req, 1'b1);
        check32("fh_refetch_addr", imem_addr, pc);
        finish_fetch(0, 0, $urandom);

        // Asynchronous reset in WAIT, late ack ignored, fresh request after release.
        tick();
        check1("ar_req", imem_req, 1'b1);
        #2;
        sys_rst = 1'b1;
        #1;
        check1("ar_req_low", imem_req, 1'b0);
        check32("ar_addr", imem_addr, 32'd0);
        check1("ar_valid", inst_valid, 1'b0);
        check1("ar_fault", fault, 1'b0);
        imem_ack = 1'b1;
        tick();
        sys_rst = 1'b0;
        tick();
        imem_ack = 1'b0;
        check1("ar_new_req", imem_req, 1'b1);
        check1("ar_ack_ignored", inst_valid, 1'b0);
        check32("ar_new_addr", imem_addr, pc);
        finish_fetch(0, 0, $urandom);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            k = $urandom_range(0, 9);
            if (k == 0) begin
                pc = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
                current_pc = pc;
                tick();
                check1("rnd_mis_fault", fault, 1'b1);
                check32("rnd_mis_cause", 32'(fault_cause), 32'd1);
                check32("rnd_mis_pc", fault_pc, pc);
                check1("rnd_mis_no_req", imem_req, 1'b0);
                pc = pc & 32'hFFFF_FFFC;
                current_pc = pc;
                clear_fault();
            end else if (k == 1) begin
                n = $urandom_range(1, TO);
                tick();
                check1("rnd_fl_req", imem_req, 1'b1);
                flush = 1'b1;
                for (int i = 0; i < n; i++) begin
                    tick();
                    flush = 1'b0;
                end
                imem_ack = 1'b1;
                imem_err = 1'($urandom_range(0, 1));
                tick();
                imem_ack = 1'b0;
                imem_err = 1'b0;
                check1("rnd_fl_no_valid", inst_valid, 1'b0);
                check1("rnd_fl_no_fault", fault, 1'b0);
                check1("rnd_fl_req_low", imem_req, 1'b0);
            end else begin
                do_fetch($urandom_range(0, TO), $urandom_range(0, 3), $urandom);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
